jump_redirect: RTL and testbench
================================

Name: jump_redirect

Overview:
- Decode-stage control-transfer resolver; the producer side of the fetch redirect/token interface.
- Decodes branches and jumps in ID, waits for forwarded operands, and evaluates the condition.
- On a taken transfer, issues a one-cycle registered redirect (is_j, j_pc) to the fetch buffer.
- Then captures the delay-slot instruction and presents it as token/j_inst.

Parameters:
RESET_PC, 32'h0000_0000, value driven on j_pc while idle and after reset.
DS_EN_DEFAULT, 1, 1 = MIPS delay-slot semantics (SLOT state used); 0 = redirect only, token never asserted.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
stop  in  1  pipeline stall from downstream; freezes state and outputs
id_valid  in  1  id_inst/id_pc hold a valid decode-stage instruction
id_inst  in  32  instruction in ID
id_pc  in  32  PC of id_inst
rs_value  in  32  forwarded rs operand
rt_value  in  32  forwarded rt operand
opnd_ready  in  1  rs/rt forwarding complete (no load-use hazard)
id_ready  out  1  ID may advance this cycle
is_j  out  1  redirect strobe, one cycle
j_pc  out  32  redirect target
token  out  1  delay-slot instruction captured, one cycle
j_inst  out  32  captured delay-slot instruction
link_we  out  1  JAL/JALR/BxxZAL link write enable, one cycle
link_addr  out  32  branch pc + 8
j_misalign  out  1  registered, asserted with is_j when the target has [1:0] != 0

Behaviour:
- Reset (resetn=0 at posedge), regardless of state:
  - state=IDLE.
  - is_j, token, link_we and j_misalign = 0.
  - j_pc = RESET_PC.
  - j_inst = 0.
  - link_addr = 0.
- Decoded set:
  - BEQ, BNE, BLEZ, BGTZ.
  - BLTZ, BGEZ, BLTZAL, BGEZAL.
  - J, JAL, JR, JALR.
  - Everything else is not a transfer.
- Target arithmetic, mod 2^32:
  - branches: id_pc + 4 + (sext(imm16) << 2).
  - J/JAL: {(id_pc+4)[31:28], idx26, 2'b00}.
  - JR/JALR: rs_value, unmodified.
- Comparisons are signed 32-bit for LEZ/GTZ/LTZ/GEZ.
- stop=1: all registers hold, all strobes hold their value; stop has priority over every transition.
- IDLE:
  - id_valid & transfer & ~opnd_ready (J/JAL need no operands, so never wait): -> WAIT_OPND, id_ready=0.
  - id_valid & transfer & resolvable & taken: latch j_pc, set is_j=1 next cycle; link_we=1 if a link instruction; link_addr=id_pc+8; -> REDIRECT.
  - Not taken: link_we still pulses for BxxZAL; state remains IDLE; no is_j.
- WAIT_OPND:
  - id_ready=0 until opnd_ready.
  - Then resolve exactly as in IDLE in the same cycle.
- REDIRECT:
  - is_j=1 for exactly one cycle.
  - -> SLOT if DS_EN_DEFAULT, else -> IDLE.
- SLOT:
  - Waits for id_valid with id_pc == branch_pc+4.
  - Captures id_inst into j_inst; token=1 for one cycle; -> IDLE.
  - Any transfer in the slot is not decoded; it is treated as ordinary.
- id_ready = 1 except in WAIT_OPND.
- Outputs are all registered: latency from decode to is_j is 1 cycle when operands are ready.
- Reset mid-REDIRECT/SLOT: the pending strobe is dropped, no token.

Optional Feature:
- Macro: JUMP_REDIRECT_STAT_EN.
- Defined: adds outputs stat_taken[31:0], stat_nottaken[31:0], stat_opnd_wait[31:0].
  - Each is incremented once per resolved taken transfer, not-taken branch, and WAIT_OPND cycle respectively.
  - Counters wrap at 2^32 and reset to 0.
  - Counters freeze under stop.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode/funct/rt constants (OP_BEQ, OP_REGIMM, FN_JR, RT_BGEZAL, ...).
  - the state enum {IDLE, WAIT_OPND, REDIRECT, SLOT}.
  - the xfer_kind typedef.
- One sub-module: jump_target_calc (combinational), which takes id_pc, id_inst and rs_value, and produces the target and misalign flag.

Test Plan:
- BEQ at id_pc=0x100, imm=0x0004, rs=rt=5, opnd_ready=1 -> next cycle is_j=1, j_pc=0x114; slot at 0x104 inst 0x2402_0001 -> token=1, j_inst=0x2402_0001.
- BNE at 0x200, imm=0xFFFF, rs=1, rt=2 -> j_pc=0x200; rs=rt -> no is_j, state stays IDLE.
- J at 0x1000, idx=0x40 -> j_pc=0x100; JAL at same PC -> link_we=1, link_addr=0x1008.
- JR with opnd_ready=0 for 3 cycles, then rs_value=0x8000_0002 -> id_ready=0 for 3 cycles, then is_j=1, j_pc=0x8000_0002, j_misalign=1.
- BGEZ taken, stop raised during REDIRECT for 2 cycles -> is_j stays 1 for 3 cycles total, then token after the slot.
- resetn=0 during SLOT -> token never asserts, j_pc=RESET_PC, and the next BEQ resolves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM state and transfer-kind types for the ID-stage
// control-transfer logic (MIPS-style branch/jump encodings).
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    typedef enum logic [1:0] {IDLE, WAIT_OPND, REDIRECT, SLOT} state_t;

    // XK_JUMP = J/JAL (no operands needed), XK_JREG = JR/JALR (target from rs)
    typedef enum logic [1:0] {XK_NONE, XK_BRANCH, XK_JUMP, XK_JREG} xfer_kind_t;

    function automatic xfer_kind_t decode_kind(input logic [31:0] inst);
        xfer_kind_t k;
        k = XK_NONE;
        case (inst[31:26])
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: k = XK_BRANCH;
            OP_REGIMM: begin
                if (inst[20:16] == RT_BLTZ || inst[20:16] == RT_BGEZ ||
                    inst[20:16] == RT_BLTZAL || inst[20:16] == RT_BGEZAL)
                    k = XK_BRANCH;
            end
            OP_J, OP_JAL: k = XK_JUMP;
            OP_SPECIAL: begin
                if (inst[5:0] == FN_JR || inst[5:0] == FN_JALR)
                    k = XK_JREG;
            end
            default: k = XK_NONE;
        endcase
        return k;
    endfunction

    function automatic logic is_link(input logic [31:0] inst);
        return (inst[31:26] == OP_JAL) ||
               (inst[31:26] == OP_SPECIAL && inst[5:0] == FN_JALR) ||
               (inst[31:26] == OP_REGIMM &&
                (inst[20:16] == RT_BLTZAL || inst[20:16] == RT_BGEZAL));
    endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational target address for the transfer in ID, plus a flag for a
// target that is not word aligned (only possible for JR/JALR).
module jump_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    input  logic [31:0] rs_value,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus4  = id_pc + 32'd4;
    assign br_target = pc_plus4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], id_inst[25:0], 2'b00};

    always_comb begin
        target = br_target;
        case (decode_kind(id_inst))
            XK_JUMP: target = j_target;
            XK_JREG: target = rs_value;
            default: target = br_target;
        endcase
    end

    assign misalign = |target[1:0];

endmodule

// File: rtl/jump_redirect.sv
// ID-stage branch/jump resolver driving the fetch redirect (is_j/j_pc) and
// delay-slot token (token/j_inst). Build with JUMP_REDIRECT_STAT_EN for counters.
module jump_redirect
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          DS_EN_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stop,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic        opnd_ready,
    output logic        id_ready,
    output logic        is_j,
    output logic [31:0] j_pc,
    output logic        token,
    output logic [31:0] j_inst,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        j_misalign,
`ifdef JUMP_REDIRECT_STAT_EN
    output logic [31:0] stat_taken,
    output logic [31:0] stat_nottaken,
    output logic [31:0] stat_opnd_wait,
`endif
    output state_t      dbg_state
);

    // Handshake: an instruction in ID is consumed on a clock edge where
    // id_valid & id_ready & ~stop; id_ready drops only while a branch/JR
    // waits for forwarded operands, so ID holds the instruction until then.

    state_t      state_q;
    logic        is_j_q, token_q, link_we_q, misalign_q;
    logic [31:0] j_pc_q, j_inst_q, link_addr_q, slot_pc_q;

    xfer_kind_t  kind;
    logic        in_dec, opnd_ok, resolve, wait_req, taken, link;
    logic [31:0] target;
    logic        tgt_misalign;

    jump_target_calc u_target (
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .rs_value (rs_value),
        .target   (target),
        .misalign (tgt_misalign)
    );

    assign kind     = decode_kind(id_inst);
    assign link     = is_link(id_inst);
    assign in_dec   = (state_q == IDLE || state_q == WAIT_OPND) && id_valid && (kind != XK_NONE);
    assign opnd_ok  = (kind == XK_JUMP) || opnd_ready;
    assign resolve  = in_dec && opnd_ok;
    assign wait_req = in_dec && !opnd_ok;
    assign id_ready = !wait_req;

    always_comb begin
        taken = 1'b1;
        case (id_inst[31:26])
            OP_BEQ:    taken = (rs_value == rt_value);
            OP_BNE:    taken = (rs_value != rt_value);
            OP_BLEZ:   taken = ($signed(rs_value) <= 32'sd0);
            OP_BGTZ:   taken = ($signed(rs_value) >  32'sd0);
            OP_REGIMM: taken = id_inst[16] ? !rs_value[31] : rs_value[31];
            default:   taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            is_j_q      <= 1'b0;
            token_q     <= 1'b0;
            link_we_q   <= 1'b0;
            misalign_q  <= 1'b0;
            j_pc_q      <= RESET_PC;
            j_inst_q    <= '0;
            link_addr_q <= '0;
            slot_pc_q   <= '0;
        end else if (!stop) begin
            is_j_q     <= 1'b0;
            token_q    <= 1'b0;
            link_we_q  <= 1'b0;
            misalign_q <= 1'b0;
            j_pc_q     <= RESET_PC;
            case (state_q)
                IDLE, WAIT_OPND: begin
                    if (resolve) begin
                        link_we_q   <= link;
                        link_addr_q <= id_pc + 32'd8;
                        if (taken) begin
                            is_j_q     <= 1'b1;
                            j_pc_q     <= target;
                            misalign_q <= tgt_misalign;
                            slot_pc_q  <= id_pc + 32'd4;
                            state_q    <= REDIRECT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (wait_req) begin
                        state_q <= WAIT_OPND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REDIRECT: state_q <= DS_EN_DEFAULT ? SLOT : IDLE;
                SLOT: begin
                    // Slot instruction is captured as-is, never decoded as a transfer
                    if (id_valid && id_pc == slot_pc_q) begin
                        j_inst_q <= id_inst;
                        token_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign is_j       = is_j_q;
    assign j_pc       = j_pc_q;
    assign token      = token_q;
    assign j_inst     = j_inst_q;
    assign link_we    = link_we_q;
    assign link_addr  = link_addr_q;
    assign j_misalign = misalign_q;
    assign dbg_state  = state_q;

`ifdef JUMP_REDIRECT_STAT_EN
    logic [31:0] stat_taken_q, stat_nottaken_q, stat_wait_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_taken_q    <= '0;
            stat_nottaken_q <= '0;
            stat_wait_q     <= '0;
        end else if (!stop) begin
            if (resolve && taken)       stat_taken_q    <= stat_taken_q + 32'd1;
            if (resolve && !taken)      stat_nottaken_q <= stat_nottaken_q + 32'd1;
            if (state_q == WAIT_OPND)   stat_wait_q     <= stat_wait_q + 32'd1;
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_nottaken  = stat_nottaken_q;
    assign stat_opnd_wait = stat_wait_q;
`endif

endmodule

// File: tb/tb_jump_redirect.sv
// Directed bench for jump_redirect: each task drives one scenario and checks
// the registered outputs one step after the active edge.
module tb_jump_redirect;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn, stop, id_valid, opnd_ready;
    logic [31:0] id_inst, id_pc, rs_value, rt_value;
    logic        id_ready, is_j, token, link_we, j_misalign;
    logic [31:0] j_pc, j_inst, link_addr;
    state_t      dbg_state;
`ifdef JUMP_REDIRECT_STAT_EN
    logic [31:0] stat_taken, stat_nottaken, stat_opnd_wait;
`endif

    int n_cmp = 0;
    int n_err = 0;

    jump_redirect #(.RESET_PC(RST_PC), .DS_EN_DEFAULT(1'b1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .stop       (stop),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
        .opnd_ready (opnd_ready),
        .id_ready   (id_ready),
        .is_j       (is_j),
        .j_pc       (j_pc),
        .token      (token),
        .j_inst     (j_inst),
        .link_we    (link_we),
        .link_addr  (link_addr),
        .j_misalign (j_misalign),
`ifdef JUMP_REDIRECT_STAT_EN
        .stat_taken     (stat_taken),
        .stat_nottaken  (stat_nottaken),
        .stat_opnd_wait (stat_opnd_wait),
`endif
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rs, input logic [31:0] rt, input logic rdy);
        id_valid = 1'b1; id_pc = pc; id_inst = inst;
        rs_value = rs; rt_value = rt; opnd_ready = rdy;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_pc = 32'h0; id_inst = 32'h0; opnd_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; stop = 1'b0; idle_id(); rs_value = 0; rt_value = 0;
        step(); step();
        resetn = 1'b1;
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL rst_is_j: got %0h want 0", is_j); end
        n_cmp++; if (token !== 1'b0) begin n_err++; $display("FAIL rst_token: got %0h want 0", token); end
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL rst_link_we: got %0h want 0", link_we); end
        n_cmp++; if (j_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %0h want 0", j_misalign); end
        n_cmp++; if (j_pc !== RST_PC) begin n_err++; $display("FAIL rst_j_pc: got %h want %h", j_pc, RST_PC); end
        n_cmp++; if (j_inst !== 32'h0) begin n_err++; $display("FAIL rst_j_inst: got %h want 0", j_inst); end
        n_cmp++; if (link_addr !== 32'h0) begin n_err++; $display("FAIL rst_link_addr: got %h want 0", link_addr); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL rst_id_ready: got %0h want 1", id_ready); end
    endtask

    // Present the delay slot at pc and expect the token two edges after redirect.
    task automatic finish_slot(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        drive(pc, inst, 32'h0, 32'h0, 1'b1);
        step();
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL %s_is_j_drop: got %0h want 0", tag, is_j); end
        n_cmp++; if (dbg_state !== SLOT) begin n_err++; $display("FAIL %s_slot_state: got %0d want %0d", tag, dbg_state, SLOT); end
        step();
        n_cmp++; if (token !== 1'b1) begin n_err++; $display("FAIL %s_token: got %0h want 1", tag, token); end
        n_cmp++; if (j_inst !== inst) begin n_err++; $display("FAIL %s_j_inst: got %h want %h", tag, j_inst, inst); end
        idle_id();
        step();
        n_cmp++; if (token !== 1'b0) begin n_err++; $display("FAIL %s_token_drop: got %0h want 0", tag, token); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL %s_idle: got %0d want %0d", tag, dbg_state, IDLE); end
    endtask

    task automatic test_beq();
        drive(32'h100, 32'h1022_0004, 32'd5, 32'd5, 1'b1);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL beq_id_ready: got %0h want 1", id_ready); end
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL beq_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h114) begin n_err++; $display("FAIL beq_j_pc: got %h want 00000114", j_pc); end
        n_cmp++; if (j_misalign !== 1'b0) begin n_err++; $display("FAIL beq_misalign: got %0h want 0", j_misalign); end
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL beq_link_we: got %0h want 0", link_we); end
        finish_slot("beq", 32'h104, 32'h2402_0001);
    endtask

    task automatic test_bne();
        drive(32'h200, 32'h1422_FFFF, 32'd1, 32'd2, 1'b1);
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL bne_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h200) begin n_err++; $display("FAIL bne_j_pc: got %h want 00000200", j_pc); end
        finish_slot("bne", 32'h204, 32'h0000_0000);
        drive(32'h200, 32'h1422_FFFF, 32'd7, 32'd7, 1'b1);
        step();
        idle_id();
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL bne_nt_is_j: got %0h want 0", is_j); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL bne_nt_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (j_pc !== RST_PC) begin n_err++; $display("FAIL bne_nt_j_pc: got %h want %h", j_pc, RST_PC); end
        step();
    endtask

    task automatic test_jump();
        drive(32'h1000, 32'h0800_0040, 32'h0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL j_id_ready: got %0h want 1", id_ready); end
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL j_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h100) begin n_err++; $display("FAIL j_j_pc: got %h want 00000100", j_pc); end
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL j_link_we: got %0h want 0", link_we); end
        finish_slot("j", 32'h1004, 32'h2403_0002);
        drive(32'h1000, 32'h0C00_0040, 32'h0, 32'h0, 1'b0);
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL jal_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h100) begin n_err++; $display("FAIL jal_j_pc: got %h want 00000100", j_pc); end
        n_cmp++; if (link_we !== 1'b1) begin n_err++; $display("FAIL jal_link_we: got %0h want 1", link_we); end
        n_cmp++; if (link_addr !== 32'h1008) begin n_err++; $display("FAIL jal_link_addr: got %h want 00001008", link_addr); end
        finish_slot("jal", 32'h1004, 32'h2404_0003);
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL jal_link_we_drop: got %0h want 0", link_we); end
    endtask

    task automatic test_jr_wait();
        drive(32'h400, 32'h0020_0008, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL jr_wait_id_ready[%0d]: got %0h want 0", i, id_ready); end
            step();
            n_cmp++; if (dbg_state !== WAIT_OPND) begin n_err++; $display("FAIL jr_wait_state[%0d]: got %0d want %0d", i, dbg_state, WAIT_OPND); end
            n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL jr_wait_is_j[%0d]: got %0h want 0", i, is_j); end
        end
        opnd_ready = 1'b1; rs_value = 32'h8000_0002;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL jr_ready_release: got %0h want 1", id_ready); end
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL jr_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h8000_0002) begin n_err++; $display("FAIL jr_j_pc: got %h want 80000002", j_pc); end
        n_cmp++; if (j_misalign !== 1'b1) begin n_err++; $display("FAIL jr_misalign: got %0h want 1", j_misalign); end
        finish_slot("jr", 32'h404, 32'h2405_0004);
        n_cmp++; if (j_misalign !== 1'b0) begin n_err++; $display("FAIL jr_misalign_drop: got %0h want 0", j_misalign); end
    endtask

    task automatic test_stop();
        drive(32'h300, 32'h0421_0010, 32'h0, 32'h0, 1'b1);
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL bgez_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h344) begin n_err++; $display("FAIL bgez_j_pc: got %h want 00000344", j_pc); end
        idle_id();
        stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL stop_is_j_hold[%0d]: got %0h want 1", i, is_j); end
            n_cmp++; if (j_pc !== 32'h344) begin n_err++; $display("FAIL stop_j_pc_hold[%0d]: got %h want 00000344", i, j_pc); end
            n_cmp++; if (dbg_state !== REDIRECT) begin n_err++; $display("FAIL stop_state_hold[%0d]: got %0d want %0d", i, dbg_state, REDIRECT); end
        end
        stop = 1'b0;
        finish_slot("bgez", 32'h304, 32'h2406_0005);
    endtask

    task automatic test_not_taken();
        drive(32'h500, 32'h0430_0008, 32'd5, 32'h0, 1'b1);
        step();
        idle_id();
        n_cmp++; if (link_we !== 1'b1) begin n_err++; $display("FAIL bltzal_link_we: got %0h want 1", link_we); end
        n_cmp++; if (link_addr !== 32'h508) begin n_err++; $display("FAIL bltzal_link_addr: got %h want 00000508", link_addr); end
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL bltzal_is_j: got %0h want 0", is_j); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL bltzal_state: got %0d want %0d", dbg_state, IDLE); end
        step();
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL bltzal_link_we_drop: got %0h want 0", link_we); end
        drive(32'h600, 32'h1C20_0002, 32'h8000_0000, 32'h0, 1'b1);
        step();
        idle_id();
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL bgtz_neg_is_j: got %0h want 0", is_j); end
        drive(32'h600, 32'h1820_0002, 32'h8000_0000, 32'h0, 1'b1);
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL blez_neg_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h60C) begin n_err++; $display("FAIL blez_j_pc: got %h want 0000060c", j_pc); end
        finish_slot("blez", 32'h604, 32'h2407_0006);
        drive(32'h700, 32'h2402_0001, 32'h0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL plain_id_ready: got %0h want 1", id_ready); end
        step();
        idle_id();
        n_cmp++; if (is_j !== 1'b0) begin n_err++; $display("FAIL plain_is_j: got %0h want 0", is_j); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL plain_state: got %0d want %0d", dbg_state, IDLE); end
    endtask

    task automatic test_reset_slot();
        drive(32'h700, 32'h1022_0004, 32'd9, 32'd9, 1'b1);
        step();
        idle_id();
        step();
        n_cmp++; if (dbg_state !== SLOT) begin n_err++; $display("FAIL rslot_state: got %0d want %0d", dbg_state, SLOT); end
        resetn = 1'b0;
        drive(32'h704, 32'h2408_0007, 32'h0, 32'h0, 1'b1);
        step();
        resetn = 1'b1;
        n_cmp++; if (token !== 1'b0) begin n_err++; $display("FAIL rslot_token: got %0h want 0", token); end
        n_cmp++; if (j_pc !== RST_PC) begin n_err++; $display("FAIL rslot_j_pc: got %h want %h", j_pc, RST_PC); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rslot_state_idle: got %0d want %0d", dbg_state, IDLE); end
        step();
        n_cmp++; if (token !== 1'b0) begin n_err++; $display("FAIL rslot_token_late: got %0h want 0", token); end
        n_cmp++; if (j_inst !== 32'h0) begin n_err++; $display("FAIL rslot_j_inst: got %h want 0", j_inst); end
        drive(32'h800, 32'h1022_0004, 32'd3, 32'd3, 1'b1);
        step();
        n_cmp++; if (is_j !== 1'b1) begin n_err++; $display("FAIL rslot_beq_is_j: got %0h want 1", is_j); end
        n_cmp++; if (j_pc !== 32'h814) begin n_err++; $display("FAIL rslot_beq_j_pc: got %h want 00000814", j_pc); end
        finish_slot("rslot_beq", 32'h804, 32'h2409_0008);
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bne();
        test_jump();
        test_jr_wait();
        test_stop();
        test_not_taken();
        test_reset_slot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
